// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor: slice width, FSM
// state encodings and the slice-counter width helper.
package nibble_serial_subtractor_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Slice counter width: clog2(width / SLICE_W), never less than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        int unsigned n;
        n = width / SLICE_W;
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/nibble_serial_subtractor_sub_slice.sv
// 4-bit combinational subtract slice: {bout_o, diff_o} = a_i - b_i - bin_i.
// Subtract mirror of the team's 4-bit adder.
// Ports:
//   a_i    [3:0]  minuend slice
//   b_i    [3:0]  subtrahend slice
//   bin_i         borrow in
//   diff_o [3:0]  difference slice
//   bout_o        borrow out
module sub_slice
    import nibble_serial_subtractor_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               bin_i,
    output logic [SLICE_W-1:0] diff_o,
    output logic               bout_o
);

    logic [SLICE_W:0] full_c;

    // One extra bit: a negative result wraps and sets the top bit, which is the borrow.
    always_comb begin
        full_c = {1'b0, a_i} - {1'b0, b_i} - (SLICE_W + 1)'(bin_i);
        diff_o = full_c[SLICE_W-1:0];
        bout_o = full_c[SLICE_W];
    end

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle unsigned subtractor d = a - b - bin over WIDTH bits, one 4-bit
// slice per clock (LSB slice first) through a single shared sub_slice.
// Optional macro SUB_OVF_FLAG_EN adds the signed-overflow output ovf.
// Ports:
//   clk, rst      clock (rising edge), synchronous active-high reset
//   start         request, accepted only while busy=0 (IDLE or DONE)
//   a, b, bin     operands, captured on the accepted start edge
//   busy          high while slices are being processed
//   done          one-cycle completion pulse
//   d, bout       registered difference and final borrow
//   ovf           signed overflow (only with SUB_OVF_FLAG_EN)
module nibble_serial_subtractor
    import nibble_serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SUB_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned N     = WIDTH / SLICE_W;
    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam int unsigned IDX_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               brw_q;
    logic [WIDTH-1:0]   res_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   d_q;
    logic               bout_q;
`ifdef SUB_OVF_FLAG_EN
    logic               ovf_q;
`endif

    logic [IDX_W-1:0]   base_c;
    logic [SLICE_W-1:0] slice_a_c;
    logic [SLICE_W-1:0] slice_b_c;
    logic [SLICE_W-1:0] slice_diff_c;
    logic               slice_bout_c;
    logic [WIDTH-1:0]   res_merged_c;

    // Select the working slice addressed by the counter (bit index = 4*cnt).
    always_comb begin
        base_c    = {cnt_q, 2'b00};
        slice_a_c = a_q[base_c +: SLICE_W];
        slice_b_c = b_q[base_c +: SLICE_W];
    end

    sub_slice u_sub_slice (
        .a_i    (slice_a_c),
        .b_i    (slice_b_c),
        .bin_i  (brw_q),
        .diff_o (slice_diff_c),
        .bout_o (slice_bout_c)
    );

    // Working result with the current slice's difference merged in.
    always_comb begin
        res_merged_c                     = res_q;
        res_merged_c[base_c +: SLICE_W]  = slice_diff_c;
    end

    // Control FSM and datapath registers; published outputs change only on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            brw_q   <= 1'b0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        brw_q   <= bin;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= BUSY;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    res_q <= res_merged_c;
                    brw_q <= slice_bout_c;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        d_q     <= res_merged_c;
                        bout_q  <= slice_bout_c;
`ifdef SUB_OVF_FLAG_EN
                        // Operands of opposite sign and result sign differs from the minuend.
                        ovf_q   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                   (res_merged_c[WIDTH-1] != a_q[WIDTH-1]);
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;
`ifdef SUB_OVF_FLAG_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor (WIDTH=16): the driver pushes
// expected results from a full-width arithmetic model; the monitor pops and
// compares on every done pulse and checks that outputs hold in between.
module tb_nibble_serial_subtractor;

    localparam int unsigned W = 16;
    localparam int unsigned N = W / 4;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
        int           due;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
`ifdef SUB_OVF_FLAG_EN
    logic         ovf;
`endif

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [W-1:0] last_d = '0;
    logic         last_bout = 1'b0;
    logic         last_ovf = 1'b0;

    nibble_serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
`ifdef SUB_OVF_FLAG_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: whole-word integer arithmetic, signed range test for overflow.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic binv, input int due);
        exp_t   e;
        longint ua, ub, r, sa, sb, sr, lim;
        lim  = longint'(1) << (W - 1);
        ua   = longint'(av);
        ub   = longint'(bv);
        r    = ua - ub - longint'(binv);
        e.d  = W'(r);
        e.bout = (ua < ub + longint'(binv));
        sa   = (ua >= lim) ? ua - 2 * lim : ua;
        sb   = (ub >= lim) ? ub - 2 * lim : ub;
        sr   = sa - sb - longint'(binv);
        e.ovf = (sr < -lim) || (sr > lim - 1);
        e.due = due;
        return e;
    endfunction

    // Monitor: compare on done, otherwise require the published result to hold.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("d", 32'(d), 32'(mon_e.d));
                    check("bout", 32'(bout), 32'(mon_e.bout));
`ifdef SUB_OVF_FLAG_EN
                    check("ovf", 32'(ovf), 32'(mon_e.ovf));
`endif
                    check("latency", 32'(cyc), 32'(mon_e.due));
                    check("busy_at_done", 32'(busy), 32'd0);
                    last_d    = mon_e.d;
                    last_bout = mon_e.bout;
                    last_ovf  = mon_e.ovf;
                end
            end else begin
                check("d_hold", 32'(d), 32'(last_d));
                check("bout_hold", 32'(bout), 32'(last_bout));
`ifdef SUB_OVF_FLAG_EN
                check("ovf_hold", 32'(ovf), 32'(last_ovf));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        check("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv);
        wait_idle();
        a     = av;
        b     = bv;
        bin   = binv;
        start = 1'b1;
        exp_q.push_back(model(av, bv, binv, cyc + 1 + int'(N)));
        tick();
        start = 1'b0;
        // Scramble inputs to show the operation in flight uses captured copies.
        a   = W'($urandom);
        b   = W'($urandom);
        bin = 1'($urandom);
    endtask

    task automatic reset_bench_state();
        exp_q.delete();
        last_d    = '0;
        last_bout = 1'b0;
        last_ovf  = 1'b0;
    endtask

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic         rbin;
        logic [W-1:0] edge_v[4];
        int           got, guard;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        edge_v[0] = 16'h0000; edge_v[1] = 16'hFFFF;
        edge_v[2] = 16'h8000; edge_v[3] = 16'h7FFF;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_d", 32'(d), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
`ifdef SUB_OVF_FLAG_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        tick();

        // Directed cases
        issue(16'h1234, 16'h0234, 1'b0);
        check("busy_after_start", 32'(busy), 32'd1);
        issue(16'h0000, 16'h0001, 1'b0);
        issue(16'h0005, 16'h0005, 1'b1);
        issue(16'h0005, 16'h0004, 1'b1);
        issue(16'h8000, 16'h0001, 1'b0);
        issue(16'h7FFF, 16'hFFFF, 1'b0);
        wait_idle();
        repeat (2) tick();

        // start held high; second op accepted in the DONE cycle
        got = 0; guard = 0;
        start = 1'b1;
        while (got < 2 && guard < 100) begin
            if (!busy) begin
                a   = (got == 0) ? 16'hA5A5 : 16'h1111;
                b   = (got == 0) ? 16'h5A5A : 16'h2222;
                bin = (got == 0) ? 1'b1 : 1'b0;
                exp_q.push_back(model(a, b, bin, cyc + 1 + int'(N)));
                got++;
            end else begin
                a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            end
            tick();
            guard++;
        end
        start = 1'b0;
        check("held_start_ops", 32'(got), 32'd2);
        wait_idle();
        repeat (2) tick();

        // Reset on the second BUSY cycle aborts the operation
        issue(16'hFFFF, 16'h0001, 1'b0);
        tick();
        rst = 1'b1;
        reset_bench_state();
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_d", 32'(d), 32'd0);
        check("abort_bout", 32'(bout), 32'd0);
        repeat (N + 3) tick();
        issue(16'h4321, 16'h1234, 1'b1);
        wait_idle();
        tick();

        // Reset together with start: reset wins
        rst = 1'b1; start = 1'b1; a = 16'h0001; b = 16'h0002; bin = 1'b0;
        reset_bench_state();
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        check("rst_start_d", 32'(d), 32'd0);
        repeat (N + 2) tick();

        // Randomized operations, biased toward boundary operands
        for (int i = 0; i < 40; i++) begin
            ra   = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : W'($urandom);
            rb   = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : W'($urandom);
            rbin = 1'($urandom);
            issue(ra, rb, rbin);
            if ($urandom_range(0, 2) == 0) begin
                wait_idle();
                repeat ($urandom_range(1, 3)) tick();
            end
        end

        // Drain remaining expectations
        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            tick();
            guard++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
